// File: rtl/npu_sram_pkg.sv
// npu_sram_pkg
//   Shared types and default sizing for the NPU SRAM load path.
//   - state_t       : load sequencer states (IDLE, FIL, IFM, DONE)
//   - *_DEF         : default global sizes used as parameter defaults
//   - DW/FW/IW_DEF  : beat-count, filter-chunk and IFM-chunk widths
//   - clog2_min1    : width helper that never returns zero
package npu_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIL  = 2'd1,
    IFM  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned BUS_SIZE_DEF         = 32;
  localparam int unsigned DAT_SIZE_DEF         = 8;
  localparam int unsigned COMPUTE_UNIT_NUM_DEF = 8;
  localparam int unsigned WR_DAT_CYC_NUM_DEF   = 64;
  localparam int unsigned SRAM_IFM_NUM_DEF     = 64;
  localparam int unsigned SRAM_FILTER_NUM_DEF  = 64;

  // A one-entry resource still needs a one-bit counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DW_DEF = clog2_min1(WR_DAT_CYC_NUM_DEF);
  localparam int unsigned FW_DEF = clog2_min1(SRAM_FILTER_NUM_DEF);
  localparam int unsigned IW_DEF = clog2_min1(SRAM_IFM_NUM_DEF);

endpackage

// File: rtl/sram_wr_port_reg.sv
// sram_wr_port_reg
//   Output register stage for one SRAM write port. A beat presented with
//   wr_en_i at a clock edge appears on the outputs for the following cycle
//   with valid_o high; valid_o drops after any cycle without wr_en_i.
//   Ports:
//     clk_i, rst_i       clock, asynchronous active-high reset
//     wr_en_i            capture this cycle's beat
//     sparsemap_i/_o     BUS_SIZE sparsemap
//     nonzero_data_i/_o  BUS_SIZE*DAT_SIZE packed nonzero data
//     dat_count_i/_o     DW-bit beat index within the chunk
//     chunk_count_i/_o   CW-bit chunk index
//     valid_o            registered write strobe
module sram_wr_port_reg #(
  parameter int unsigned BUS_SIZE = 32,
  parameter int unsigned DAT_SIZE = 8,
  parameter int unsigned DW       = 6,
  parameter int unsigned CW       = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [BUS_SIZE-1:0]          sparsemap_i,
  input  logic [BUS_SIZE*DAT_SIZE-1:0] nonzero_data_i,
  input  logic [DW-1:0]                dat_count_i,
  input  logic [CW-1:0]                chunk_count_i,
  output logic                         valid_o,
  output logic [BUS_SIZE-1:0]          sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0] nonzero_data_o,
  output logic [DW-1:0]                dat_count_o,
  output logic [CW-1:0]                chunk_count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o        <= 1'b0;
      sparsemap_o    <= '0;
      nonzero_data_o <= '0;
      dat_count_o    <= '0;
      chunk_count_o  <= '0;
    end else begin
      valid_o <= wr_en_i;
      if (wr_en_i) begin
        sparsemap_o    <= sparsemap_i;
        nonzero_data_o <= nonzero_data_i;
        dat_count_o    <= dat_count_i;
        chunk_count_o  <= chunk_count_i;
      end
    end
  end

endmodule

// File: rtl/sram_load_ctrl.sv
// sram_load_ctrl
//   Load sequencer for the filter and IFM SRAM write ports. One compressed
//   stream (sparsemap + packed nonzero data) arrives over valid/ready. For
//   each channel slice, COMPUTE_UNIT_NUM filter chunks are written first,
//   then cfg_ifm_y IFM chunks; finish_o pulses when the layer is loaded.
//   Ports:
//     clk_i, rst_i                 clock, asynchronous active-high reset
//     start_i                      begin a load (sampled in IDLE only)
//     busy_o, finish_o             loading / one-cycle completion pulse
//     cfg_*_i                      layer geometry, latched on start
//     in_valid_i, in_ready_o       input beat handshake
//     in_sparsemap_i, in_nonzero_data_i  input beat payload
//     fil_sram_wr_*_o              registered filter SRAM write port
//     ifm_sram_wr_*_o              registered IFM SRAM write port
module sram_load_ctrl
  import npu_sram_pkg::*;
#(
  parameter int unsigned BUS_SIZE         = BUS_SIZE_DEF,
  parameter int unsigned DAT_SIZE         = DAT_SIZE_DEF,
  parameter int unsigned COMPUTE_UNIT_NUM = COMPUTE_UNIT_NUM_DEF,
  parameter int unsigned WR_DAT_CYC_NUM   = WR_DAT_CYC_NUM_DEF,
  parameter int unsigned SRAM_IFM_NUM     = SRAM_IFM_NUM_DEF,
  parameter int unsigned SRAM_FILTER_NUM  = SRAM_FILTER_NUM_DEF,
  localparam int unsigned DW  = clog2_min1(WR_DAT_CYC_NUM),
  localparam int unsigned FW  = clog2_min1(SRAM_FILTER_NUM),
  localparam int unsigned IW  = clog2_min1(SRAM_IFM_NUM),
  localparam int unsigned DBW = BUS_SIZE * DAT_SIZE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                finish_o,
  input  logic [7:0]          cfg_z_num_i,
  input  logic [DW:0]         cfg_fil_cyc_i,
  input  logic [7:0]          cfg_ifm_y_i,
  input  logic [DW:0]         cfg_ifm_cyc_i,
  input  logic [DW:0]         cfg_ifm_last_cyc_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [BUS_SIZE-1:0] in_sparsemap_i,
  input  logic [DBW-1:0]      in_nonzero_data_i,
  output logic [BUS_SIZE-1:0] fil_sram_wr_sparsemap_o,
  output logic [DBW-1:0]      fil_sram_wr_nonzero_data_o,
  output logic                fil_sram_wr_valid_o,
  output logic [DW-1:0]       fil_sram_wr_dat_count_o,
  output logic [FW-1:0]       fil_sram_wr_chunk_count_o,
  output logic [BUS_SIZE-1:0] ifm_sram_wr_sparsemap_o,
  output logic [DBW-1:0]      ifm_sram_wr_nonzero_data_o,
  output logic                ifm_sram_wr_valid_o,
  output logic [DW-1:0]       ifm_sram_wr_dat_count_o,
  output logic [IW-1:0]       ifm_sram_wr_chunk_count_o
);

  localparam int unsigned CUW = clog2_min1(COMPUTE_UNIT_NUM);
  localparam logic [DW:0]    BEAT_ONE = (DW+1)'(1);
  localparam logic [CUW-1:0] CU_ONE   = CUW'(1);
  localparam logic [CUW-1:0] CU_LAST  = CUW'(COMPUTE_UNIT_NUM - 1);

  state_t state_q, state_d;

  // Latched configuration
  logic [7:0]     z_num_q;
  logic [7:0]     ifm_y_q;
  logic [DW:0]    fil_cyc_q;
  logic [DW:0]    ifm_cyc_q;
  logic [DW:0]    ifm_last_q;

  // Position within the layer
  logic [DW:0]    beat_q;
  logic [CUW-1:0] cu_q;
  logic [7:0]     z_q;
  logic [7:0]     y_q;

  logic           in_ready;
  logic           accept;
  logic           fil_wr_en;
  logic           ifm_wr_en;
  logic           cfg_zero;
  logic           last_slice;
  logic           last_cu;
  logic           last_y;
  logic           fil_last_beat;
  logic           ifm_last_beat;
  logic [DW:0]    ifm_lim;
  logic [FW-1:0]  fil_chunk;
  logic [IW-1:0]  ifm_chunk;

  // Status decode over the current position
  always_comb begin
    cfg_zero      = (cfg_z_num_i == 8'd0) || (cfg_ifm_y_i == 8'd0) ||
                    (cfg_fil_cyc_i == '0) || (cfg_ifm_cyc_i == '0) ||
                    (cfg_ifm_last_cyc_i == '0);
    last_slice    = (z_q == z_num_q - 8'd1);
    last_cu       = (cu_q == CU_LAST);
    last_y        = (y_q == ifm_y_q - 8'd1);
    ifm_lim       = last_slice ? ifm_last_q : ifm_cyc_q;
    fil_last_beat = (beat_q == fil_cyc_q - BEAT_ONE);
    ifm_last_beat = (beat_q == ifm_lim - BEAT_ONE);
    // Products formed at 32 bits, then truncated to the port width.
    fil_chunk     = FW'(32'(z_q) * 32'(COMPUTE_UNIT_NUM) + 32'(cu_q));
    ifm_chunk     = IW'(32'(z_q) * 32'(ifm_y_q) + 32'(y_q));
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = cfg_zero ? DONE : FIL;
      FIL:  if (accept && fil_last_beat && last_cu) state_d = IFM;
      IFM:  if (accept && ifm_last_beat && last_y) state_d = last_slice ? DONE : FIL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == FIL) || (state_q == IFM);
    accept    = in_ready && in_valid_i;
    fil_wr_en = accept && (state_q == FIL);
    ifm_wr_en = accept && (state_q == IFM);
    busy_o    = in_ready;
    finish_o  = (state_q == DONE);
  end

  assign in_ready_o = in_ready;

  // Configuration latch and position counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      z_num_q    <= '0;
      ifm_y_q    <= '0;
      fil_cyc_q  <= '0;
      ifm_cyc_q  <= '0;
      ifm_last_q <= '0;
      beat_q     <= '0;
      cu_q       <= '0;
      z_q        <= '0;
      y_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            z_num_q    <= cfg_z_num_i;
            ifm_y_q    <= cfg_ifm_y_i;
            fil_cyc_q  <= cfg_fil_cyc_i;
            ifm_cyc_q  <= cfg_ifm_cyc_i;
            ifm_last_q <= cfg_ifm_last_cyc_i;
            beat_q     <= '0;
            cu_q       <= '0;
            z_q        <= '0;
            y_q        <= '0;
          end
        end
        FIL: begin
          if (accept) begin
            if (fil_last_beat) begin
              beat_q <= '0;
              cu_q   <= last_cu ? '0 : cu_q + CU_ONE;
            end else begin
              beat_q <= beat_q + BEAT_ONE;
            end
          end
        end
        IFM: begin
          if (accept) begin
            if (ifm_last_beat) begin
              beat_q <= '0;
              if (last_y) begin
                y_q <= '0;
                z_q <= z_q + 8'd1;
              end else begin
                y_q <= y_q + 8'd1;
              end
            end else begin
              beat_q <= beat_q + BEAT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sram_wr_port_reg #(
    .BUS_SIZE (BUS_SIZE),
    .DAT_SIZE (DAT_SIZE),
    .DW       (DW),
    .CW       (FW)
  ) u_fil_port (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_en_i        (fil_wr_en),
    .sparsemap_i    (in_sparsemap_i),
    .nonzero_data_i (in_nonzero_data_i),
    .dat_count_i    (beat_q[DW-1:0]),
    .chunk_count_i  (fil_chunk),
    .valid_o        (fil_sram_wr_valid_o),
    .sparsemap_o    (fil_sram_wr_sparsemap_o),
    .nonzero_data_o (fil_sram_wr_nonzero_data_o),
    .dat_count_o    (fil_sram_wr_dat_count_o),
    .chunk_count_o  (fil_sram_wr_chunk_count_o)
  );

  sram_wr_port_reg #(
    .BUS_SIZE (BUS_SIZE),
    .DAT_SIZE (DAT_SIZE),
    .DW       (DW),
    .CW       (IW)
  ) u_ifm_port (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_en_i        (ifm_wr_en),
    .sparsemap_i    (in_sparsemap_i),
    .nonzero_data_i (in_nonzero_data_i),
    .dat_count_i    (beat_q[DW-1:0]),
    .chunk_count_i  (ifm_chunk),
    .valid_o        (ifm_sram_wr_valid_o),
    .sparsemap_o    (ifm_sram_wr_sparsemap_o),
    .nonzero_data_o (ifm_sram_wr_nonzero_data_o),
    .dat_count_o    (ifm_sram_wr_dat_count_o),
    .chunk_count_o  (ifm_sram_wr_chunk_count_o)
  );

endmodule

// File: tb/tb_sram_load_ctrl.sv
module tb_sram_load_ctrl;

  localparam int unsigned BUS  = 16;
  localparam int unsigned DAT  = 8;
  localparam int unsigned CU   = 2;
  localparam int unsigned WRC  = 8;
  localparam int unsigned IFMN = 16;
  localparam int unsigned FILN = 16;
  localparam int unsigned DW   = 3;
  localparam int unsigned FW   = 4;
  localparam int unsigned IW   = 4;
  localparam int unsigned DBW  = BUS * DAT;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            busy_o;
  logic            finish_o;
  logic [7:0]      cfg_z_num_i;
  logic [DW:0]     cfg_fil_cyc_i;
  logic [7:0]      cfg_ifm_y_i;
  logic [DW:0]     cfg_ifm_cyc_i;
  logic [DW:0]     cfg_ifm_last_cyc_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [BUS-1:0]  in_sparsemap_i;
  logic [DBW-1:0]  in_nonzero_data_i;
  logic [BUS-1:0]  fil_sm, ifm_sm;
  logic [DBW-1:0]  fil_nz, ifm_nz;
  logic            fil_v, ifm_v;
  logic [DW-1:0]   fil_dat, ifm_dat;
  logic [FW-1:0]   fil_chk;
  logic [IW-1:0]   ifm_chk;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  sram_load_ctrl #(
    .BUS_SIZE         (BUS),
    .DAT_SIZE         (DAT),
    .COMPUTE_UNIT_NUM (CU),
    .WR_DAT_CYC_NUM   (WRC),
    .SRAM_IFM_NUM     (IFMN),
    .SRAM_FILTER_NUM  (FILN)
  ) dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .start_i                    (start_i),
    .busy_o                     (busy_o),
    .finish_o                   (finish_o),
    .cfg_z_num_i                (cfg_z_num_i),
    .cfg_fil_cyc_i              (cfg_fil_cyc_i),
    .cfg_ifm_y_i                (cfg_ifm_y_i),
    .cfg_ifm_cyc_i              (cfg_ifm_cyc_i),
    .cfg_ifm_last_cyc_i         (cfg_ifm_last_cyc_i),
    .in_valid_i                 (in_valid_i),
    .in_ready_o                 (in_ready_o),
    .in_sparsemap_i             (in_sparsemap_i),
    .in_nonzero_data_i          (in_nonzero_data_i),
    .fil_sram_wr_sparsemap_o    (fil_sm),
    .fil_sram_wr_nonzero_data_o (fil_nz),
    .fil_sram_wr_valid_o        (fil_v),
    .fil_sram_wr_dat_count_o    (fil_dat),
    .fil_sram_wr_chunk_count_o  (fil_chk),
    .ifm_sram_wr_sparsemap_o    (ifm_sm),
    .ifm_sram_wr_nonzero_data_o (ifm_nz),
    .ifm_sram_wr_valid_o        (ifm_v),
    .ifm_sram_wr_dat_count_o    (ifm_dat),
    .ifm_sram_wr_chunk_count_o  (ifm_chk)
  );

  task automatic chk(input string tag, input logic [DBW-1:0] obs, input logic [DBW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   busy_o,     0);
    chk({tag, "_ready"},  in_ready_o, 0);
    chk({tag, "_finish"}, finish_o,   0);
    chk({tag, "_fil_v"},  fil_v,      0);
    chk({tag, "_ifm_v"},  ifm_v,      0);
    chk({tag, "_fil_cnt"}, {fil_chk, fil_dat}, 0);
    chk({tag, "_ifm_cnt"}, {ifm_chk, ifm_dat}, 0);
    chk({tag, "_fil_dat"}, {fil_sm, fil_nz}, 0);
    chk({tag, "_ifm_dat"}, {ifm_sm, ifm_nz}, 0);
  endtask

  // mode: 0 = valid always high, 1 = valid every other cycle, 2 = random valid.
  // abort_at > 0: assert reset once that many beats have been accepted.
  task automatic run_load(input int z, input int fil, input int y, input int cyc,
                          input int last, input int mode, input bit glitch,
                          input int abort_at);
    int              e_port[$];
    int              e_chunk[$];
    int              e_dat[$];
    logic [BUS-1:0]  b_sm[$];
    logic [DBW-1:0]  b_nz[$];
    int              n, sent, seen;
    bit              fin, exp_fin, prev_acc, want;
    int              lim;

    // Reference: the full ordered write list for this layer.
    if (z > 0 && fil > 0 && y > 0 && cyc > 0 && last > 0) begin
      for (int zi = 0; zi < z; zi++) begin
        for (int c = 0; c < int'(CU); c++)
          for (int b = 0; b < fil; b++) begin
            e_port.push_back(0);
            e_chunk.push_back((zi * int'(CU) + c) % (1 << FW));
            e_dat.push_back(b);
          end
        lim = (zi == z - 1) ? last : cyc;
        for (int yi = 0; yi < y; yi++)
          for (int b = 0; b < lim; b++) begin
            e_port.push_back(1);
            e_chunk.push_back((zi * y + yi) % (1 << IW));
            e_dat.push_back(b);
          end
      end
    end
    n = e_port.size();
    for (int i = 0; i < n; i++) begin
      b_sm.push_back(BUS'($urandom));
      b_nz.push_back({$urandom, $urandom, $urandom, $urandom});
    end

    @(negedge clk_i);
    cfg_z_num_i        = 8'(z);
    cfg_fil_cyc_i      = (DW+1)'(fil);
    cfg_ifm_y_i        = 8'(y);
    cfg_ifm_cyc_i      = (DW+1)'(cyc);
    cfg_ifm_last_cyc_i = (DW+1)'(last);
    start_i    = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    cfg_z_num_i = 8'($urandom);
    cfg_fil_cyc_i = '0;

    sent = 0; seen = 0; fin = 0; prev_acc = 0;
    for (int cyc_n = 0; cyc_n < 2000 && !fin; cyc_n++) begin
      if (cyc_n > 0) @(negedge clk_i);
      chk("both_ports_valid", fil_v & ifm_v, 0);
      chk("wr_valid", fil_v | ifm_v, prev_acc);
      if (fil_v || ifm_v) begin
        if (seen < n) begin
          chk("wr_port", ifm_v, e_port[seen]);
          chk("wr_chunk", ifm_v ? ifm_chk : fil_chk, e_chunk[seen]);
          chk("wr_dat_count", ifm_v ? ifm_dat : fil_dat, e_dat[seen]);
          chk("wr_sparsemap", ifm_v ? ifm_sm : fil_sm, b_sm[seen]);
          chk("wr_nonzero", ifm_v ? ifm_nz : fil_nz, b_nz[seen]);
        end else begin
          chk("extra_write", 1, 0);
        end
        seen++;
      end
      exp_fin = (sent == n);
      chk("in_ready", in_ready_o, !exp_fin);
      chk("busy", busy_o, !exp_fin);
      chk("finish", finish_o, exp_fin);
      if (exp_fin) begin
        fin = 1;
        chk("writes_by_finish", seen, n);
      end else if (abort_at > 0 && sent == abort_at) begin
        rst_i = 1'b1;
        #1;
        chk_all_zero("async_reset");
        in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          chk("reset_no_finish", finish_o, 0);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("after_reset_idle", {busy_o, in_ready_o, finish_o, fil_v, ifm_v}, 0);
        return;
      end else begin
        case (mode)
          0:       want = 1'b1;
          1:       want = (cyc_n % 2 == 1);
          default: want = ($urandom_range(0, 1) == 1);
        endcase
        in_valid_i        = want;
        in_sparsemap_i    = b_sm[sent];
        in_nonzero_data_i = b_nz[sent];
        start_i           = glitch ? ($urandom_range(0, 1) == 1) : 1'b0;
        prev_acc          = want && in_ready_o;
        if (prev_acc) sent++;
      end
    end
    if (!fin) chk("finish_timeout", 0, 1);

    in_valid_i = 1'b0;
    start_i    = 1'b0;
    @(negedge clk_i);
    chk("finish_one_cycle", finish_o, 0);
    chk("post_idle", {busy_o, in_ready_o, fil_v, ifm_v}, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    in_valid_i = 1'b0;
    in_sparsemap_i = '0;
    in_nonzero_data_i = '0;
    cfg_z_num_i = '0;
    cfg_fil_cyc_i = '0;
    cfg_ifm_y_i = '0;
    cfg_ifm_cyc_i = '0;
    cfg_ifm_last_cyc_i = '0;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset_state");
    rst_i = 1'b0;

    // Basic load, continuous valid
    run_load(1, 3, 2, 2, 2, 0, 0, 0);
    // Last slice uses its own beat count; slice 1 filter chunks start at CU
    run_load(2, 3, 1, 4, 1, 0, 0, 0);
    // Same basic sequence with valid toggling
    run_load(1, 3, 2, 2, 2, 1, 0, 0);
    // Degenerate configurations
    run_load(0, 3, 2, 2, 2, 0, 0, 0);
    run_load(1, 0, 2, 2, 2, 0, 0, 0);
    run_load(1, 3, 0, 2, 2, 0, 0, 0);
    run_load(2, 3, 2, 2, 0, 0, 0, 0);
    // Reset during filter beat 2, then a clean restart
    run_load(1, 4, 2, 2, 2, 0, 0, 2);
    run_load(1, 4, 2, 2, 2, 0, 0, 0);
    // start_i toggled while busy
    run_load(1, 3, 2, 2, 2, 0, 1, 0);
    // Beat limit equal to WR_DAT_CYC_NUM
    run_load(1, 8, 1, 8, 8, 0, 0, 0);
    // Chunk counts exceeding the port width wrap by truncation
    run_load(5, 1, 4, 1, 2, 2, 0, 0);
    // Random layers with random valid
    for (int r = 0; r < 6; r++)
      run_load($urandom_range(1, 3), $urandom_range(1, 8), $urandom_range(1, 4),
               $urandom_range(1, 8), $urandom_range(1, 8), 2,
               ($urandom_range(0, 1) == 1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
